// File: rtl/mul4_dot_acc.sv
// Dot-product accumulator for the 4x4 multiplier's product stream: sums LEN
// products per frame and presents the sum with a sticky carry-out flag.
module mul4_dot_acc #(
    parameter int PROD_W = 8,
    parameter int LEN    = 4,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic             accept_s;
    logic             cnt_last_s;
    logic [ACC_W:0]   add_s;

    // In HOLD the sink handshake passes straight through so a consumed result
    // and the next frame's first beat can share a cycle.
    assign in_ready   = (state_q == HOLD) ? out_ready : 1'b1;
    assign accept_s   = in_valid && in_ready;
    assign cnt_last_s = (cnt_q == CNT_W'(LEN - 1));
    assign add_s      = {1'b0, acc_q} + (ACC_W + 1)'(in_prod);

    assign out_valid  = (state_q == HOLD);
    assign out_sum    = sum_q;
    assign out_ovf    = ovf_q;
    assign busy       = (cnt_q != {CNT_W{1'b0}});

    // Next-state: frame accumulation, result capture and hand-off.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;

        case (state_q)
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end else begin
                    state_d = HOLD;
                end
            end
            ACC: begin
                state_d = ACC;
            end
            default: begin
                state_d = ACC;
            end
        endcase

        // acc/ovf_acc are already cleared after a last beat, so a beat taken
        // in HOLD naturally starts the next frame from zero.
        if (accept_s) begin
            if (cnt_last_s) begin
                sum_d     = add_s[ACC_W-1:0];
                ovf_d     = ovf_acc_q | add_s[ACC_W];
                acc_d     = {ACC_W{1'b0}};
                ovf_acc_d = 1'b0;
                cnt_d     = {CNT_W{1'b0}};
                state_d   = HOLD;
            end else begin
                acc_d     = add_s[ACC_W-1:0];
                ovf_acc_d = ovf_acc_q | add_s[ACC_W];
                cnt_d     = cnt_q + CNT_W'(1);
            end
        end else begin
            acc_d     = acc_q;
            ovf_acc_d = ovf_acc_q;
            cnt_d     = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            acc_q     <= {ACC_W{1'b0}};
            ovf_acc_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            sum_q     <= {ACC_W{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mul4_dot_acc.sv
// Directed bench for mul4_dot_acc: a default instance and a 9-bit-accumulator
// instance share one stimulus stream so overflow can be observed alongside.
module tb_mul4_dot_acc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_prod;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [11:0] out_sum;
    logic        in_ready9, out_valid9, out_ovf9, busy9;
    logic [8:0]  out_sum9;

    int checks = 0;
    int errors = 0;

    mul4_dot_acc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    mul4_dot_acc #(.PROD_W(8), .LEN(4), .ACC_W(9), .CNT_W(2)) dut9 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready9), .in_prod(in_prod),
        .out_valid(out_valid9), .out_ready(out_ready),
        .out_sum(out_sum9), .out_ovf(out_ovf9), .busy(busy9)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] prod);
        in_valid = 1'b1;
        in_prod  = prod;
        check("beat_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_prod = 8'hFF; out_ready = 1'b1;

        // Reset with a valid beat present
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_no_phantom", 32'(busy), 32'd0);

        // Basic frame 15 + 225 + 0 + 1 = 241
        beat(8'd15);
        beat(8'd225);
        beat(8'd0);
        check("basic_busy_mid", 32'(busy), 32'd1);
        beat(8'd1);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_sum",   32'(out_sum),   32'd241);
        check("basic_ovf",   32'(out_ovf),   32'd0);
        check("basic_busy",  32'(busy),      32'd0);
        tick();
        check("basic_consumed", 32'(out_valid), 32'd0);

        // Back-pressure with a bubble: 4 x 225 = 900 (388 with ovf on 9 bits)
        out_ready = 1'b0;
        beat(8'd225);
        beat(8'd225);
        tick();
        check("bubble_busy", 32'(busy), 32'd1);
        beat(8'd225);
        beat(8'd225);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_sum",   32'(out_sum),   32'd900);
        check("bp_ovf",   32'(out_ovf),   32'd0);
        check("ovf9_sum", 32'(out_sum9),  32'd388);
        check("ovf9_ovf", 32'(out_ovf9),  32'd1);
        in_valid = 1'b1; in_prod = 8'd7;
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold9_in_ready", 32'(in_ready9), 32'd0);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum",   32'(out_sum),   32'd900);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("release_valid", 32'(out_valid), 32'd0);
        check("hold_ignored",  32'(busy),      32'd0);

        // Sticky overflow clears per frame
        for (int i = 0; i < 4; i++) beat(8'd1);
        check("ovf9_next_sum", 32'(out_sum9), 32'd4);
        check("ovf9_next_ovf", 32'(out_ovf9), 32'd0);
        check("next_sum",      32'(out_sum),  32'd4);
        tick();

        // Full throughput: 8 beats of 10 back to back
        in_valid = 1'b1; in_prod = 8'd10;
        for (int i = 1; i <= 8; i++) begin
            check("tp_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 4 || i == 8) begin
                check("tp_valid", 32'(out_valid), 32'd1);
                check("tp_sum",   32'(out_sum),   32'd40);
            end else if (i == 5) begin
                check("tp_consumed",  32'(out_valid), 32'd0);
                check("tp_overlap",   32'(busy),      32'd1);
            end else begin
                check("tp_busy", 32'(busy), 32'd1);
            end
        end
        in_valid = 1'b0;
        tick();
        check("tp_drained", 32'(out_valid), 32'd0);

        // Mid-frame reset discards partial 200
        beat(8'd100);
        beat(8'd100);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        beat(8'd1);
        beat(8'd2);
        beat(8'd3);
        beat(8'd4);
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_sum",   32'(out_sum),   32'd10);
        check("mid_ovf",   32'(out_ovf),   32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
